stop_watch_ctrl: RTL and testbench
==================================

Name: stop_watch_ctrl

Overview:
- Front-panel controller that sequences the stop_watch block from two raw push-buttons.
- Synchronises and debounces the START/STOP and LAP/RESET buttons, then runs the run/pause/lap/clear state machine.
- Issues the single-cycle start_stop and clear pulses that stop_watch expects.
- Freezes a lap (split) time for display while stop_watch keeps counting; sits between the board buttons/7-seg driver and stop_watch.

Parameters:
DEB_CNT, 4, consecutive stable synchronised samples required to accept a button level change (range 2..2^16-1; boards use ~1e6).

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
btn_ss  input  1  raw START/STOP button, active-high, asynchronous to clk
btn_lap  input  1  raw LAP/RESET button, active-high, asynchronous to clk
time_in  input  24  live stop_watch digits {hr_h,hr_l,min_h,min_l,sec_h,sec_l}, 4-bit BCD each
start_stop  output  1  one-cycle toggle pulse to stop_watch.start_stop
clear  output  1  one-cycle pulse to stop_watch.clear
disp  output  24  digits to display, same packing as time_in
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
state  output  2  current FSM state encoding

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, start_stop=0, clear=0, lap_reg=0, running=0, lap_active=0.
  - Synchronisers, debounced levels and debounce counters all 0.
  - disp follows time_in immediately.
- Input conditioning, per button:
  - 2-FF synchroniser.
  - Width-16 debounce counter: cleared whenever the synchronised sample equals the debounced level; otherwise increments.
  - When the counter reaches DEB_CNT-1 and the sample still differs, the debounced level updates and the counter clears.
  - Press event = one-cycle strobe on the debounced 0->1 transition. Release generates nothing.
  - Glitches shorter than DEB_CNT cycles produce no event.
- Latency:
  - A raw rise first sampled at edge N and held stable gives a press event in the cycle after edge N+DEB_CNT+2.
  - Output pulses are registered: start_stop/clear are high exactly one cycle, during the cycle after edge N+DEB_CNT+3.
- FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
  - IDLE: ss press -> start_stop pulse, go RUN. Lap press ignored.
  - RUN: ss press -> start_stop pulse, go PAUSE. Lap press -> lap_reg<=time_in (value at the event cycle), go LAP.
  - LAP: ss press -> start_stop pulse, go PAUSE (lap discarded, display live). Lap press -> go RUN (display live again). stop_watch keeps counting throughout LAP.
  - PAUSE: ss press -> start_stop pulse, go RUN. Lap press -> clear pulse, lap_reg<=0, go IDLE.
- Simultaneous ss and lap events in the same cycle: the ss event wins and the lap event is discarded.
- start_stop and clear are never high in the same cycle; at most one pulse per event.
- Holding a button produces exactly one event per press; there is no auto-repeat.
- disp = lap_active ? lap_reg : time_in (combinational mux). lap_reg is passed through without BCD validation.
- running = (state==RUN)||(state==LAP); lap_active = (state==LAP). Both are decoded from registered state.
- Reset mid-operation, including during a debounce count or a pending pulse: everything returns to reset values asynchronously, no pulse is emitted, and a button held through reset release is accepted as a new press after the debounce latency.

Test Plan:
- Conditions: DEB_CNT=4, clk period 10 ns.
- Reset check: hold rst_n=0, drive buttons -> state=00, start_stop=clear=0, disp==time_in.
- Start: hold btn_ss high 100 ns -> exactly one start_stop pulse 7 edges after first sampling edge; state 00->01; running=1.
- Debounce: btn_ss 30 ns glitch -> no event, state unchanged. Bounce 1/0/1 every 10 ns, then stable 100 ns -> exactly one pulse.
- Lap: in RUN with time_in=24'h000123, press lap -> state=11, disp stays 000123 while time_in advances to 000130. Press lap again -> state=01, disp==time_in.
- Pause/clear: RUN, ss press -> one start_stop pulse, state=10. Lap press -> one clear pulse, state=00, lap_reg=0.
- Simultaneous press and reset: both buttons rise on the same edge in RUN -> only start_stop pulse, state=10. Assert rst_n=0 while counting a press -> no pulse; after release with button held -> one pulse at debounce latency.

Source files
------------

// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: front-panel sequencer for the stop_watch block.
// Conditions two raw push-buttons and drives stop_watch from them. Each
// button is synchronised and debounced. A clean press then steps the
// run/pause/lap/clear state machine, which issues single-cycle control pulses.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn_ss     raw START/STOP button (active high, asynchronous)
//   btn_lap    raw LAP/RESET button (active high, asynchronous)
//   time_in    live digits {hr_h,hr_l,min_h,min_l,sec_h,sec_l}, BCD
//   start_stop one-cycle toggle pulse to stop_watch
//   clear      one-cycle clear pulse to stop_watch
//   disp       digits to display (frozen lap time while in LAP)
//   running    high in RUN or LAP
//   lap_active high in LAP
//   state      current FSM state encoding
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | cleared and stopped; a lap press is ignored
// RUN   | counting, display live
// PAUSE | stopped; a lap press clears the stop_watch
// LAP   | counting, display frozen at the captured split

module stop_watch_ctrl #(
  parameter int unsigned DEB_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic [23:0] time_in,
  output logic        start_stop,
  output logic        clear,
  output logic [23:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [15:0] DEB_LAST = 16'(DEB_CNT - 1);

  // Bit 0 is START/STOP and bit 1 is LAP/RESET throughout.
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  level;
  logic [1:0]  level_d;
  logic [1:0]  press;
  logic [15:0] cnt [2];

  state_t      st;
  logic [23:0] lap_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
    end else begin
      sync1   <= {btn_lap, btn_ss};
      sync2   <= sync1;
      level_d <= level;
      // The press strobe is registered. It fires one cycle after the
      // debounced level rises. A release produces no strobe.
      press   <= level & ~level_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // A START/STOP event takes priority. A lap event arriving in the same cycle
  // is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      start_stop <= 1'b0;
      clear      <= 1'b0;
      lap_reg    <= '0;
    end else begin
      start_stop <= 1'b0;
      clear      <= 1'b0;
      if (press[0]) begin
        start_stop <= 1'b1;
        case (st)
          IDLE:    st <= RUN;
          RUN:     st <= PAUSE;
          LAP:     st <= PAUSE;
          PAUSE:   st <= RUN;
          default: st <= IDLE;
        endcase
      end else if (press[1]) begin
        case (st)
          RUN: begin
            lap_reg <= time_in;
            st      <= LAP;
          end
          LAP:   st <= RUN;
          PAUSE: begin
            clear   <= 1'b1;
            lap_reg <= '0;
            st      <= IDLE;
          end
          default: st <= st;
        endcase
      end
    end
  end

  assign state      = st;
  assign running    = (st == RUN) || (st == LAP);
  assign lap_active = (st == LAP);
  assign disp       = lap_active ? lap_reg : time_in;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Testbench for stop_watch_ctrl. Stimulus pushes the expected pulses into a
// scoreboard queue. Each entry records the pulse kind and the cycle in which
// the pulse must appear. A separate monitor pops an entry whenever a pulse is
// seen and compares it. State and display values are checked directly.

module tb_stop_watch_ctrl;

  localparam int DEB = 4;
  // The button is driven at a negedge. The first sampling edge is the next
  // posedge N, and the pulse must be high in the cycle after edge N+DEB+3.
  localparam int LAT = DEB + 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_ss;
  logic        btn_lap;
  logic [23:0] time_in;
  logic        start_stop;
  logic        clear;
  logic [23:0] disp;
  logic        running;
  logic        lap_active;
  logic [1:0]  state;

  typedef struct {
    int kind;   // 1 = start_stop, 2 = clear
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  stop_watch_ctrl #(.DEB_CNT(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_ss     (btn_ss),
    .btn_lap    (btn_lap),
    .time_in    (time_in),
    .start_stop (start_stop),
    .clear      (clear),
    .disp       (disp),
    .running    (running),
    .lap_active (lap_active),
    .state      (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (start_stop || clear) begin
      if (start_stop && clear) begin
        n_tests++;
        n_fail++;
        $display("FAIL pulse_overlap: start_stop and clear both high at cycle %0d", cyc);
      end else if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", start_stop ? 1 : 2, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", start_stop ? 1 : 2, e.kind);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // Press one or both buttons for 'hold' cycles, then release and let the
  // release settle. kind = expected pulse (0 none, 1 start_stop, 2 clear).
  task automatic press(input bit ss, input bit lap, input int kind, input int hold);
    @(negedge clk);
    btn_ss  = ss;
    btn_lap = lap;
    if (kind != 0) sb.push_back('{kind: kind, cyc: cyc + LAT});
    repeat (hold) @(negedge clk);
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_ss  = 1'b1;
    btn_lap = 1'b1;
    time_in = 24'h000042;
    repeat (4) @(negedge clk);
    check("rst_state", state, 2'b00);
    check("rst_start_stop", start_stop, 1'b0);
    check("rst_clear", clear, 1'b0);
    check("rst_disp", disp, 24'h000042);
    check("rst_running", running, 1'b0);
    check("rst_lap_active", lap_active, 1'b0);
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Lap is ignored in IDLE.
    press(1'b0, 1'b1, 0, 10);
    check("idle_lap_ignored", state, 2'b00);

    // Start.
    press(1'b1, 1'b0, 1, 10);
    check("start_state", state, 2'b01);
    check("start_running", running, 1'b1);

    // Three-cycle glitch is rejected.
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (3) @(negedge clk);
    btn_ss = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_state", state, 2'b01);

    // Bounce 1/0/1, then stable: one pulse timed from the final rise.
    @(negedge clk);
    btn_ss = 1'b1;
    @(negedge clk);
    btn_ss = 1'b0;
    press(1'b1, 1'b0, 1, 10);
    check("bounce_state", state, 2'b10);

    // Resume to RUN.
    press(1'b1, 1'b0, 1, 10);
    check("resume_state", state, 2'b01);

    // Lap freezes the display while the stop_watch keeps counting.
    time_in = 24'h000123;
    press(1'b0, 1'b1, 0, 10);
    time_in = 24'h000130;
    @(negedge clk);
    check("lap_state", state, 2'b11);
    check("lap_active", lap_active, 1'b1);
    check("lap_running", running, 1'b1);
    check("lap_disp_frozen", disp, 24'h000123);

    press(1'b0, 1'b1, 0, 10);
    check("unlap_state", state, 2'b01);
    check("unlap_disp_live", disp, 24'h000130);

    // LAP followed by START/STOP goes to PAUSE with a live display.
    press(1'b0, 1'b1, 0, 10);
    check("lap2_disp", disp, 24'h000130);
    time_in = 24'h000200;
    press(1'b1, 1'b0, 1, 10);
    check("lap_pause_state", state, 2'b10);
    check("lap_pause_disp", disp, 24'h000200);
    check("lap_pause_running", running, 1'b0);

    // Clear from PAUSE.
    press(1'b0, 1'b1, 2, 10);
    check("clear_state", state, 2'b00);
    check("clear_disp", disp, 24'h000200);

    // Into RUN, then a simultaneous press: START/STOP wins.
    press(1'b1, 1'b0, 1, 10);
    check("run2_state", state, 2'b01);
    press(1'b1, 1'b1, 1, 10);
    check("simul_state", state, 2'b10);
    check("simul_lap_active", lap_active, 1'b0);

    // Reset in the middle of a debounce count; button held through release.
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_state", state, 2'b00);
    check("midrst_start_stop", start_stop, 1'b0);
    rst_n = 1'b1;
    sb.push_back('{kind: 1, cyc: cyc + LAT});
    repeat (12) @(negedge clk);
    btn_ss = 1'b0;
    repeat (12) @(negedge clk);
    check("postrst_state", state, 2'b01);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("FAIL missing_pulse: kind %0d expected at cycle %0d, got none", e.kind, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
